// File: rtl/uart_axi_ctrl.sv
// Sequences status polls, TX FIFO writes and RX FIFO reads on an AXI UART Lite via an AXI-Lite handshake FSM.
// Optional UART_AXI_FIFO_RESET_EN: after reset, write CTRL to clear the UART FIFOs before any other access.

module uart_axi_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module uart_axi_ctrl #(
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int RETRY_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        re,
  output logic        we,
  output logic [3:0]  araddr,
  output logic [3:0]  awaddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata,
  input  logic        r_success,
  input  logic        r_timeout,
  input  logic        w_success,
  input  logic        w_busy,
  output logic        err
);
  localparam int TW = $clog2(RETRY_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE,
    STAT_REQ,
    STAT_WAIT,
    TX_REQ,
    TX_WAIT,
    RX_REQ,
    RX_WAIT,
`ifdef UART_AXI_FIFO_RESET_EN
    INIT_REQ,
    INIT_WAIT,
`endif
    HALT
  } state_t;

`ifdef UART_AXI_FIFO_RESET_EN
  localparam state_t RESET_STATE = INIT_REQ;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          seen_busy;
  logic          last_tx;
  logic [3:0]    araddr_q, awaddr_q, wstrb_q;
  logic [31:0]   wdata_q;
  logic          tx_pop, rx_push;
  logic [7:0]    tx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          rx_ok, tx_ok;
  logic          unused_rdata;

  assign unused_rdata = ^rdata[31:8];

  uart_axi_ctrl_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .push_data(tx_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_axi_ctrl_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rdata[7:0]),
    .pop(rx_ready), .head(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign err      = (state == HALT);
  assign timeout  = (timer == TW'(RETRY_CYCLES - 1));

  // Decision inputs evaluated on the STAT response itself
  assign rx_ok = rdata[0] && !rx_full;
  assign tx_ok = !tx_empty && !rdata[3];

  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state)
      IDLE:      if (!tx_empty || !rx_full) state_next = STAT_REQ;
      STAT_REQ:  state_next = STAT_WAIT;
      STAT_WAIT: begin
        if (r_success) begin
          if (rx_ok && (last_tx || !tx_ok)) state_next = RX_REQ;
          else if (tx_ok)                   state_next = TX_REQ;
          else                              state_next = IDLE;
        end else if (r_timeout) state_next = HALT;
        else if (timeout)       state_next = STAT_REQ;
      end
      TX_REQ:    state_next = TX_WAIT;
      TX_WAIT: begin
        if (w_success) begin
          tx_pop     = 1'b1;
          state_next = IDLE;
        end else if ((seen_busy && !w_busy) || timeout) state_next = STAT_REQ;
      end
      RX_REQ:    state_next = RX_WAIT;
      RX_WAIT: begin
        if (r_success) begin
          rx_push    = 1'b1;
          state_next = IDLE;
        end else if (r_timeout) state_next = HALT;
        else if (timeout)       state_next = RX_REQ;
      end
`ifdef UART_AXI_FIFO_RESET_EN
      INIT_REQ:  state_next = INIT_WAIT;
      INIT_WAIT: begin
        if (w_success)                                  state_next = IDLE;
        else if ((seen_busy && !w_busy) || timeout)     state_next = INIT_REQ;
      end
`endif
      HALT:      state_next = HALT;
      default:   state_next = RESET_STATE;
    endcase
  end

  // Strobes last exactly one cycle because every *_REQ state exits unconditionally
  always_comb begin
    re     = (state == STAT_REQ) || (state == RX_REQ);
    we     = (state == TX_REQ);
    araddr = araddr_q;
    awaddr = awaddr_q;
    wdata  = wdata_q;
    wstrb  = wstrb_q;
    case (state)
      STAT_REQ: araddr = 4'h8;
      RX_REQ:   araddr = 4'h0;
      TX_REQ: begin
        awaddr = 4'h4;
        wdata  = {24'h0, tx_head};
        wstrb  = 4'b0001;
      end
`ifdef UART_AXI_FIFO_RESET_EN
      INIT_REQ: begin
        we     = 1'b1;
        awaddr = 4'hC;
        wdata  = 32'h3;
        wstrb  = 4'b0001;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_STATE;
      timer     <= '0;
      seen_busy <= 1'b0;
      last_tx   <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state    <= state_next;
      araddr_q <= araddr;
      awaddr_q <= awaddr;
      wdata_q  <= wdata;
      wstrb_q  <= wstrb;
      if (state_next != state)             timer <= '0;
      else if (timer != TW'(RETRY_CYCLES)) timer <= timer + TW'(1);
      if (we)          seen_busy <= 1'b0;
      else if (w_busy) seen_busy <= 1'b1;
      if (tx_pop)       last_tx <= 1'b1;
      else if (rx_push) last_tx <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_axi_ctrl.sv
// Directed bench for uart_axi_ctrl: STAT decision table plus retry, SLVERR, fairness, halt and reset sequences.
module tb_uart_axi_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        re, we;
  logic [3:0]  araddr, awaddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        r_success, r_timeout, w_success, w_busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  uart_axi_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .RETRY_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .re(re), .we(we), .araddr(araddr), .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .r_success(r_success), .r_timeout(r_timeout),
    .w_success(w_success), .w_busy(w_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stat;
    int         ntx;
    logic [7:0] txb;
    logic [7:0] rxb;
    int         kind;   // 1 = read strobe, 2 = write strobe
    logic [3:0] addr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; rdata = 32'h0;
    r_success = 1'b0; r_timeout = 1'b0; w_success = 1'b0; w_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Looks at the current negedge first, then advances up to budget cycles
  task automatic wait_strobe(input int budget, output int kind, output logic [31:0] addr, output int waited);
    kind = 0; addr = 32'h0; waited = 0;
    for (int i = 0; i <= budget && kind == 0; i++) begin
      if (re || we) begin
        kind   = re ? 1 : 2;
        addr   = re ? {28'h0, araddr} : {28'h0, awaddr};
        waited = i;
      end else if (i < budget) begin
        tick();
      end
    end
  endtask

  task automatic expect_strobe(input string name, input int exp_kind, input logic [3:0] exp_addr);
    int k; logic [31:0] a; int w;
    wait_strobe(200, k, a, w);
    check({name, ".kind"}, k, exp_kind);
    check({name, ".addr"}, a, {28'h0, exp_addr});
  endtask

  task automatic push_n(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1; tx_data = b + 8'(i);
      tick();
    end
    tx_valid = 1'b0;
  endtask

  task automatic read_resp(input logic [31:0] d);
    tick();
    rdata = d; r_success = 1'b1;
    tick();
    r_success = 1'b0;
  endtask

  task automatic write_ok();
    tick(); w_busy = 1'b1;
    tick(); w_busy = 1'b0; w_success = 1'b1;
    tick(); w_success = 1'b0;
  endtask

  task automatic write_err();
    tick(); w_busy = 1'b1;
    tick(); w_busy = 1'b0;
  endtask

  initial begin
    int k, w, strobes;
    logic [31:0] a;

    vecs[0] = '{8'h00, 1, 8'h41, 8'h00, 2, 4'h4};
    vecs[1] = '{8'h01, 0, 8'h00, 8'h5A, 1, 4'h0};
    vecs[2] = '{8'h00, 0, 8'h00, 8'h00, 1, 4'h8};
    vecs[3] = '{8'h08, 1, 8'h33, 8'h00, 1, 4'h8};
    vecs[4] = '{8'h09, 2, 8'h77, 8'hC3, 1, 4'h0};
    vecs[5] = '{8'h08, 0, 8'h00, 8'h00, 1, 4'h8};
    vecs[6] = '{8'hF6, 1, 8'h9E, 8'h00, 2, 4'h4};

    // Reset state, sampled while rst is held
    do_reset();
    rst = 1'b1;
    tick();
    check("rst.re", re, 0);         check("rst.we", we, 0);
    check("rst.araddr", araddr, 0); check("rst.awaddr", awaddr, 0);
    check("rst.wdata", wdata, 0);   check("rst.wstrb", wstrb, 0);
    check("rst.err", err, 0);       check("rst.rx_valid", rx_valid, 0);
    check("rst.tx_ready", tx_ready, 1);
    rst = 1'b0;

    // STAT decision table
    foreach (vecs[v]) begin
      do_reset();
      expect_strobe($sformatf("v%0d.poll", v), 1, 4'h8);
      push_n(vecs[v].ntx, vecs[v].txb);
      read_resp({24'h0, vecs[v].stat});
      expect_strobe($sformatf("v%0d.act", v), vecs[v].kind, vecs[v].addr);
      if (vecs[v].kind == 2) begin
        check($sformatf("v%0d.wdata", v), wdata, {24'h0, vecs[v].txb});
        check($sformatf("v%0d.wstrb", v), {28'h0, wstrb}, 32'h1);
        write_ok();
      end else if (vecs[v].addr == 4'h0) begin
        read_resp({24'h0, vecs[v].rxb});
        check($sformatf("v%0d.rx_valid", v), rx_valid, 1);
        check($sformatf("v%0d.rx_data", v), rx_data, vecs[v].rxb);
      end
    end

    // TX single byte: one-cycle strobes, pop only on w_success
    do_reset();
    expect_strobe("tx.poll", 1, 4'h8);
    tick();
    check("tx.re_pulse", re, 0);
    push_n(1, 8'h41);
    check("tx.tx_ready", tx_ready, 1);
    read_resp(32'h0);
    expect_strobe("tx.write", 2, 4'h4);
    check("tx.wdata", wdata, 32'h41);
    tick();
    check("tx.we_pulse", we, 0);
    check("tx.awaddr_hold", awaddr, 4'h4);
    check("tx.wdata_hold", wdata, 32'h41);
    write_ok();
    expect_strobe("tx.repoll", 1, 4'h8);
    read_resp(32'h0);
    expect_strobe("tx.empty", 1, 4'h8);

    // RX pop by the CPU
    rx_ready = 1'b0;
    read_resp(32'h1);
    expect_strobe("rx.read", 1, 4'h0);
    read_resp(32'h5A);
    check("rx.valid", rx_valid, 1);
    check("rx.data", rx_data, 8'h5A);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx.popped", rx_valid, 0);

    // TX blocked by STAT[3], then drained in order
    do_reset();
    expect_strobe("full.poll0", 1, 4'h8);
    push_n(3, 8'h11);
    for (int i = 0; i < 3; i++) begin
      read_resp(32'h8);
      expect_strobe($sformatf("full.blocked%0d", i), 1, 4'h8);
    end
    for (int i = 0; i < 3; i++) begin
      read_resp(32'h0);
      expect_strobe($sformatf("full.wr%0d", i), 2, 4'h4);
      check($sformatf("full.data%0d", i), wdata, 32'h11 + 32'(i));
      write_ok();
      expect_strobe($sformatf("full.poll%0d", i + 1), 1, 4'h8);
    end
    read_resp(32'h0);
    expect_strobe("full.drained", 1, 4'h8);

    // SLVERR: byte kept, rewritten after a fresh STAT poll, popped once
    do_reset();
    expect_strobe("slv.poll", 1, 4'h8);
    push_n(1, 8'h5C);
    read_resp(32'h0);
    expect_strobe("slv.wr0", 2, 4'h4);
    write_err();
    expect_strobe("slv.repoll", 1, 4'h8);
    read_resp(32'h0);
    expect_strobe("slv.wr1", 2, 4'h4);
    check("slv.data", wdata, 32'h5C);
    write_ok();
    expect_strobe("slv.poll2", 1, 4'h8);
    read_resp(32'h0);
    expect_strobe("slv.once", 1, 4'h8);

    // Fairness: after a TX, a pending RX is served before the next TX
    do_reset();
    expect_strobe("fair.poll", 1, 4'h8);
    push_n(2, 8'hA1);
    read_resp(32'h0);
    expect_strobe("fair.tx0", 2, 4'h4);
    write_ok();
    expect_strobe("fair.poll1", 1, 4'h8);
    read_resp(32'h1);
    expect_strobe("fair.rx", 1, 4'h0);
    read_resp(32'h66);
    check("fair.rx_data", rx_data, 8'h66);
    expect_strobe("fair.poll2", 1, 4'h8);
    read_resp(32'h1);
    expect_strobe("fair.tx1", 2, 4'h4);
    check("fair.tx1_data", wdata, 32'hA2);
    write_ok();

    // Retry after 64 silent wait cycles, then r_timeout halts
    do_reset();
    expect_strobe("retry.poll", 1, 4'h8);
    tick();
    wait_strobe(200, k, a, w);
    check("retry.kind", k, 1);
    check("retry.gap", w + 1, 65);
    tick();
    r_timeout = 1'b1;
    tick();
    check("halt.err", err, 1);
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      if (re || we) strobes++;
      tick();
    end
    check("halt.no_strobes", strobes, 0);
    check("halt.err_sticky", err, 1);
    do_reset();
    check("halt.err_cleared", err, 0);

    // 16 pushes fill the FIFO, the 17th is dropped
    do_reset();
    expect_strobe("ovf.poll", 1, 4'h8);
    push_n(16, 8'h01);
    check("ovf.full", tx_ready, 0);
    push_n(1, 8'hEE);
    check("ovf.still_full", tx_ready, 0);
    for (int i = 0; i < 16; i++) begin
      expect_strobe($sformatf("ovf.poll%0d", i), 1, 4'h8);
      read_resp(32'h0);
      expect_strobe($sformatf("ovf.wr%0d", i), 2, 4'h4);
      check($sformatf("ovf.data%0d", i), wdata, 32'h01 + 32'(i));
      write_ok();
    end
    expect_strobe("ovf.last_poll", 1, 4'h8);
    read_resp(32'h0);
    expect_strobe("ovf.dropped", 1, 4'h8);

    // Reset in the middle of TX_WAIT
    do_reset();
    expect_strobe("mid.poll", 1, 4'h8);
    push_n(2, 8'h90);
    read_resp(32'h0);
    expect_strobe("mid.wr", 2, 4'h4);
    tick();
    rst = 1'b1;
    tick();
    check("mid.tx_ready", tx_ready, 1);
    check("mid.err", err, 0);
    check("mid.we", we, 0);
    check("mid.awaddr", awaddr, 0);
    check("mid.wdata", wdata, 0);
    rst = 1'b0;
    wait_strobe(200, k, a, w);
    check("mid.idle_then_poll", w, 1);
    read_resp(32'h0);
    expect_strobe("mid.fifo_empty", 1, 4'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
